// File: rtl/jtag_sync_pkg.sv
// Shared types and defaults for the JTAG/debug pin synchroniser bank.
package jtag_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned SyncStagesDefault   = 3;
    localparam int unsigned FilterCyclesDefault = 0;

    // Filter counter must hold 0..filter_cycles; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned filter_cycles);
        if (filter_cycles < 1) begin
            return 1;
        end
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/jtag_sync_edge_ch.sv
// One channel: synchroniser chain, persistence filter, edge detect and sticky event flag.
module jtag_sync_edge_ch
    import jtag_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SyncStagesDefault,
    parameter int unsigned FILTER_CYCLES = FilterCyclesDefault,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sig_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       event_o,
    output logic       pending_o
);

    localparam int unsigned     CntW   = cnt_width(FILTER_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_last;
    logic                   level_q, level_d;
    logic                   prev_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pending_q, pending_d;

    assign s_last = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after it has differed from level_q for
    // FILTER_CYCLES+1 consecutive cycles; any return restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s_last != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = s_last;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        event_o = 1'b0;
        unique case (edge_mode_e'(mode_i))
            EDGE_OFF:  event_o = 1'b0;
            EDGE_RISE: event_o = rise_o;
            EDGE_FALL: event_o = fall_o;
            EDGE_BOTH: event_o = rise_o | fall_o;
        endcase
    end

    // Set has priority over clear.
    assign pending_d = (pending_q & ~clr_i) | event_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= {SYNC_STAGES{RESET_VAL}};
            level_q   <= RESET_VAL;
            prev_q    <= RESET_VAL;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_i};
            level_q   <= level_d;
            prev_q    <= level_q;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = level_q & ~prev_q;
    assign fall_o    = ~level_q & prev_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/jtag_sync_edge_bank.sv
// Bank of independent synchroniser/edge-detect channels for slow asynchronous pad inputs.
module jtag_sync_edge_bank
    import jtag_sync_pkg::*;
#(
    parameter int unsigned NCH           = 4,
    parameter int unsigned SYNC_STAGES   = SyncStagesDefault,
    parameter int unsigned FILTER_CYCLES = FilterCyclesDefault,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NCH-1:0]   sig_i,
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   clr_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   rise_o,
    output logic [NCH-1:0]   fall_o,
    output logic [NCH-1:0]   event_o,
    output logic [NCH-1:0]   pending_o
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        jtag_sync_edge_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_VAL    (RESET_VAL)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .sig_i    (sig_i[g]),
            .mode_i   (mode_i[2*g +: 2]),
            .clr_i    (clr_i[g]),
            .level_o  (level_o[g]),
            .rise_o   (rise_o[g]),
            .fall_o   (fall_o[g]),
            .event_o  (event_o[g]),
            .pending_o(pending_o[g])
        );
    end

endmodule

// File: tb/tb_jtag_sync_edge_bank.sv
// Self-checking bench: three bank configurations driven together, checked against a history-based model.
module tb_jtag_sync_edge_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig, clr;
    logic [7:0] mode;

    logic [3:0] lvl_a, rise_a, fall_a, ev_a, pend_a;
    logic [3:0] lvl_b, rise_b, fall_b, ev_b, pend_b;
    logic [1:0] lvl_c, rise_c, fall_c, ev_c, pend_c;

    always #5 clk = ~clk;

    jtag_sync_edge_bank #(.NCH(4), .SYNC_STAGES(3), .FILTER_CYCLES(0), .RESET_VAL(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .sig_i(sig), .mode_i(mode), .clr_i(clr),
        .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .event_o(ev_a), .pending_o(pend_a)
    );
    jtag_sync_edge_bank #(.NCH(4), .SYNC_STAGES(3), .FILTER_CYCLES(2), .RESET_VAL(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .sig_i(sig), .mode_i(mode), .clr_i(clr),
        .level_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .event_o(ev_b), .pending_o(pend_b)
    );
    jtag_sync_edge_bank #(.NCH(2), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .sig_i(sig[1:0]), .mode_i(mode[3:0]), .clr_i(clr[1:0]),
        .level_o(lvl_c), .rise_o(rise_c), .fall_o(fall_c), .event_o(ev_c), .pending_o(pend_c)
    );

    int P_SYNC[3] = '{3, 3, 2};
    int P_FILT[3] = '{0, 2, 1};
    int P_NCH[3]  = '{4, 4, 2};
    bit P_RV[3]   = '{1'b0, 1'b0, 1'b1};

    int n_chk = 0;
    int n_pass = 0;

    // Model: every sampled input is kept; the synchronised value seen at edge x is
    // the sample taken SYNC edges earlier (or the reset value if that predates reset).
    logic [3:0] sig_hist [0:4095];
    int         e = 0;
    int         r = 0;
    bit         m_valid = 1'b0;
    bit         m_lvl [3][4];
    bit         m_prv [3][4];
    bit         m_pend[3][4];

    function automatic bit m_d(input int i, input int c, input int x);
        int y;
        y = x - P_SYNC[i];
        if (y > r) return sig_hist[y][c];
        return P_RV[i];
    endfunction

    function automatic bit m_ev(input int i, input int c, input logic [1:0] md);
        bit rs, fl;
        rs = m_lvl[i][c] & ~m_prv[i][c];
        fl = ~m_lvl[i][c] & m_prv[i][c];
        case (md)
            2'b01:   return rs;
            2'b10:   return fl;
            2'b11:   return rs | fl;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit acc;
        e++;
        sig_hist[e] = sig;
        if (!rst_n) begin
            r = e;
            m_valid = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < P_NCH[i]; c++) begin
                if (!rst_n) begin
                    m_lvl[i][c]  = P_RV[i];
                    m_prv[i][c]  = P_RV[i];
                    m_pend[i][c] = 1'b0;
                end else begin
                    m_pend[i][c] = (m_pend[i][c] & ~clr[c]) | m_ev(i, c, mode[2*c +: 2]);
                    // Flip once the opposite value has been seen at this edge and the
                    // FILTER edges before it, all after the last reset.
                    acc = 1'b1;
                    for (int k = 0; k <= P_FILT[i]; k++) begin
                        if ((e - k) <= r || m_d(i, c, e - k) == m_lvl[i][c]) acc = 1'b0;
                    end
                    m_prv[i][c] = m_lvl[i][c];
                    if (acc) m_lvl[i][c] = ~m_lvl[i][c];
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        logic [3:0] el, er, ef, ee, ep, al, ar, af, ae, ap;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int i = 0; i < 3; i++) begin
                    el = '0; er = '0; ef = '0; ee = '0; ep = '0;
                    for (int c = 0; c < P_NCH[i]; c++) begin
                        el[c] = m_lvl[i][c];
                        er[c] = m_lvl[i][c] & ~m_prv[i][c];
                        ef[c] = ~m_lvl[i][c] & m_prv[i][c];
                        ee[c] = m_ev(i, c, mode[2*c +: 2]);
                        ep[c] = m_pend[i][c];
                    end
                    case (i)
                        0: begin al = lvl_a; ar = rise_a; af = fall_a; ae = ev_a; ap = pend_a; end
                        1: begin al = lvl_b; ar = rise_b; af = fall_b; ae = ev_b; ap = pend_b; end
                        default: begin
                            al = {2'b00, lvl_c}; ar = {2'b00, rise_c}; af = {2'b00, fall_c};
                            ae = {2'b00, ev_c};  ap = {2'b00, pend_c};
                        end
                    endcase
                    chk($sformatf("model u%0d level", i), 32'(al), 32'(el));
                    chk($sformatf("model u%0d rise", i), 32'(ar), 32'(er));
                    chk($sformatf("model u%0d fall", i), 32'(af), 32'(ef));
                    chk($sformatf("model u%0d event", i), 32'(ae), 32'(ee));
                    chk($sformatf("model u%0d pending", i), 32'(ap), 32'(ep));
                end
            end
        end
    end

    initial begin
        int cnt, cr, cf, bad;
        rst_n = 1'b0;
        sig   = 4'h0;
        clr   = 4'h0;
        mode  = 8'h55;
        tick(2);
        chk("reset lvl_a", 32'(lvl_a), 32'h0);
        chk("reset pend_a", 32'(pend_a), 32'h0);
        chk("reset lvl_c", 32'(lvl_c), 32'h3);
        chk("reset ev_b", 32'(ev_b), 32'h0);
        rst_n = 1'b1;
        tick(8);

        // Default latency: stable from before edge 1, visible after edge 4.
        sig[0] = 1'b1;
        tick(4);
        chk("lat lvl_a0", 32'(lvl_a[0]), 32'h1);
        chk("lat rise_a0", 32'(rise_a[0]), 32'h1);
        chk("lat ev_a0", 32'(ev_a[0]), 32'h1);
        chk("lat pend_a0 early", 32'(pend_a[0]), 32'h0);
        tick(1);
        chk("pulse width rise_a0", 32'(rise_a[0]), 32'h0);
        chk("pend_a0 set", 32'(pend_a[0]), 32'h1);
        clr[0] = 1'b1;
        tick(1);
        chk("pend_a0 cleared", 32'(pend_a[0]), 32'h0);
        chk("filter lat lvl_b0", 32'(lvl_b[0]), 32'h1);
        chk("filter lat rise_b0", 32'(rise_b[0]), 32'h1);
        clr[0] = 1'b0;
        tick(6);

        // Glitch shorter than the filter, then one just long enough.
        sig[1] = 1'b1;
        tick(2);
        sig[1] = 1'b0;
        tick(8);
        chk("glitch lvl_b1", 32'(lvl_b[1]), 32'h0);
        sig[1] = 1'b1;
        tick(3);
        sig[1] = 1'b0;
        tick(2);
        chk("3cyc lvl_b1 edge5", 32'(lvl_b[1]), 32'h0);
        tick(1);
        chk("3cyc lvl_b1 edge6", 32'(lvl_b[1]), 32'h1);
        chk("3cyc rise_b1", 32'(rise_b[1]), 32'h1);
        tick(10);

        // Square wave, period 8, both edges then falls only.
        mode[5:4] = 2'b11;
        cnt = 0; cr = 0; cf = 0;
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 0) sig[2] = ~sig[2];
            tick(1);
            cnt += int'(ev_a[2]);
            cr += int'(rise_a[2]);
            cf += int'(fall_a[2]);
        end
        chk("both events", 32'(cnt), 32'd8);
        chk("both rises", 32'(cr), 32'd4);
        chk("both falls", 32'(cf), 32'd4);
        mode[5:4] = 2'b10;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) sig[2] = ~sig[2];
            tick(1);
            cnt += int'(ev_a[2]);
        end
        chk("fall-only events", 32'(cnt), 32'd2);
        tick(8);

        // Set and clear in the same cycle, then clear alone.
        sig[3] = 1'b1;
        tick(3);
        clr[3] = 1'b1;
        tick(1);
        chk("setclr ev_a3", 32'(ev_a[3]), 32'h1);
        tick(1);
        chk("setclr pend_a3 kept", 32'(pend_a[3]), 32'h1);
        tick(1);
        chk("clr pend_a3", 32'(pend_a[3]), 32'h0);
        clr[3] = 1'b0;
        tick(4);

        // Reset while u_b ch0 is mid-filter with level high.
        sig[0] = 1'b0;
        tick(4);
        chk("midfilter lvl_b0", 32'(lvl_b[0]), 32'h1);
        rst_n = 1'b0;
        sig = 4'h0;
        tick(1);
        chk("midrst lvl_b", 32'(lvl_b), 32'h0);
        chk("midrst pend_b", 32'(pend_b), 32'h0);
        chk("midrst fall_b", 32'(fall_b), 32'h0);
        chk("midrst pend_a", 32'(pend_a), 32'h0);
        chk("midrst lvl_c", 32'(lvl_c), 32'h3);
        tick(1);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            cnt += $countones(fall_a) + $countones(fall_b) + $countones(ev_a) + $countones(ev_b);
        end
        chk("no spurious fall", 32'(cnt), 32'd0);

        // Reset value 1 with inputs high through release.
        rst_n = 1'b0;
        sig = 4'b0011;
        tick(2);
        rst_n = 1'b1;
        cnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            cnt += $countones(rise_c);
            if (lvl_c !== 2'b11) bad++;
        end
        chk("rv1 no rise", 32'(cnt), 32'd0);
        chk("rv1 level held", 32'(bad), 32'd0);

        // Mode off neither sets nor clears pending.
        chk("off pend_a0 before", 32'(pend_a[0]), 32'h1);
        mode[1:0] = 2'b00;
        sig[0] = 1'b0;
        tick(8);
        chk("off lvl_a0", 32'(lvl_a[0]), 32'h0);
        chk("off pend_a0 kept", 32'(pend_a[0]), 32'h1);
        clr[0] = 1'b1;
        tick(1);
        chk("off pend_a0 clr", 32'(pend_a[0]), 32'h0);
        clr[0] = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtag_sync_edge_bank.md
Name: jtag_sync_edge_bank

Overview:
Multi-channel synchroniser and edge detector for slow asynchronous control inputs (JTAG TCK/TMS/TRST, debug request pins) sampled in the SoC clock domain.
- Generalises the single-channel 3-flop TCK rising-edge enable.
- Adds per-channel:
  - configurable synchroniser depth;
  - optional glitch filter;
  - selectable edge mode (rise/fall/both);
  - sticky event flag with software clear.
- Sits between pad inputs and the JTAG TAP / debug logic.

Parameters:
NCH, 4, number of independent channels (>=1)
SYNC_STAGES, 3, synchroniser flops per channel (>=2)
FILTER_CYCLES, 0, extra consecutive cycles a new synchronised level must persist before acceptance (0 = no filter)
RESET_VAL, 1'b0, reset value of every sync flop and filtered level, so reset never produces a spurious edge

Ports:
clk_i  in  1  single clock
rst_ni  in  1  reset, synchronous, active-low
sig_i  in  NCH  asynchronous input signals
mode_i  in  NCH*2  per-channel edge mode: 00 off, 01 rise, 10 fall, 11 both
clr_i  in  NCH  per-channel clear of pending_o
level_o  out  NCH  filtered synchronised level
rise_o  out  NCH  1-cycle pulse on accepted 0->1 of level_o
fall_o  out  NCH  1-cycle pulse on accepted 1->0 of level_o
event_o  out  NCH  rise_o/fall_o gated by mode_i
pending_o  out  NCH  sticky event flag

Behaviour:
- Clock and reset: all state is updated on the rising edge of clk_i. When rst_ni=0 at an edge:
  - sync chain and level register <= RESET_VAL;
  - previous-level register <= RESET_VAL;
  - filter counter <= 0;
  - pending <= 0.
- Outputs held under reset: level_o=RESET_VAL; rise_o, fall_o, event_o, pending_o = 0.
- Reset asserted mid-filter or mid-pulse discards all in-flight state.
- Sync chain: s[0] <= sig_i; s[k] <= s[k-1]. s_last = s[SYNC_STAGES-1].
- Filter (per channel, counter width clog2(FILTER_CYCLES+1), minimum 1 bit):
  - s_last == level_q: cnt <= 0.
  - s_last != level_q and cnt == FILTER_CYCLES: level_q <= s_last, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - An s_last excursion lasting <= FILTER_CYCLES cycles is rejected with no output activity. The counter restarts from 0 on any return to level_q.
- Latency: sig_i stable from before edge 1 gives level_o updated after edge SYNC_STAGES+1+FILTER_CYCLES.
  - Defaults: sig_i stable before edge 1 gives level_o updated after edge 4.
- Edge detect:
  - level_d <= level_q.
  - rise_o = level_q & ~level_d; fall_o = ~level_q & level_d.
  - Each pulse is exactly one cycle, coincident with the first cycle of the new level_o.
- event_o is combinational from the current mode_i:
  - 00 -> 0;
  - 01 -> rise_o;
  - 10 -> fall_o;
  - 11 -> rise_o|fall_o.
  - A mode change takes effect in the same cycle.
- pending:
  - pending <= (pending & ~clr_i) | event_o.
  - Set and clear in the same cycle: set wins, pending stays 1.
  - Mode 00 never sets pending but does not clear it.
- Channels are fully independent; no cross-channel coherency is guaranteed.
- Timing: no combinational path from sig_i to any output. mode_i -> event_o is the only comb path; clr_i affects pending_o next cycle.

Decomposition:
- Package jtag_sync_pkg:
  - edge_mode_e enum (EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11);
  - default constants for SYNC_STAGES and FILTER_CYCLES.
- Sub-module jtag_sync_edge_ch: one channel (sync chain, filter, edge detect, pending), parametrised by SYNC_STAGES, FILTER_CYCLES and RESET_VAL.
- Top instantiates NCH copies via generate.

Test Plan:
- Defaults (NCH=4, SYNC_STAGES=3, FILTER_CYCLES=0, RESET_VAL=0, mode_i=01): sig_i[0] 0->1 before edge 1 -> level_o[0]=1 and rise_o[0]=event_o[0]=1 after edge 4, pulse exactly 1 cycle; pending_o[0]=1 from edge 5 until clr_i.
- FILTER_CYCLES=2: 2-cycle high glitch on sig_i[1] -> no level_o/rise_o/event_o change. 3-cycle high -> level_o[1] rises after edge SYNC_STAGES+3 from first sampled high.
- mode_i[2]=11: TCK-like square wave, period 8 cycles -> event_o[2] pulses every 4 cycles, alternating with rise_o/fall_o. Switch to 10 mid-run -> only falls reported from the switch cycle.
- pending: event_o[3] and clr_i[3] in same cycle -> pending_o[3] stays 1. clr_i alone next cycle -> pending_o[3]=0 the following cycle.
- Reset mid-operation: assert rst_ni=0 while a channel filter count is nonzero and level_o=1 -> all outputs at reset values after that edge. After release with sig_i=0 -> no spurious fall_o/event_o.
- RESET_VAL=1 with sig_i held high through reset release -> no rise_o, level_o stays 1 throughout.
